sha_frame_rx: RTL and testbench

Upstream framing stage for the UART SHA-256 path. Sits between the UART receiver and the SHA-256 processor. It replaces single-byte start/terminator signalling with a length-prefixed frame, so payloads may contain any byte value, including 0x01 and 0xFF. It validates the length, forwards payload bytes with exact `start`/`data_valid`/`data_last` timing, and reports malformed or stalled frames.

---
 rtl/sha_frame_pkg.sv | 18 +
 rtl/sha_frame_rx_if.sv | 12 +
 rtl/frame_timeout_timer.sv | 29 ++
 rtl/sha_frame_rx.sv | 151 +++++++++++++++
 tb/tb_sha_frame_rx.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha_frame_pkg.sv
// Shared types and constants for the length-prefixed SHA-256 framing stage.
package sha_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEN_HI  = 2'd1,
        LEN_LO  = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_BUSY    = 2'd3;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/sha_frame_rx_if.sv
// Byte bus from the framer to the SHA-256 processor.
// Handshake: data_in is meaningful only in the single cycle data_valid is high;
// there is no back-pressure, the processor must take every strobe.
interface sha_frame_rx_if;
    logic       start;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_last;

    modport master (output start, output data_in, output data_valid, output data_last);
    modport slave  (input  start, input  data_in, input  data_valid, input  data_last);
endinterface

// File: rtl/frame_timeout_timer.sv
// Inter-byte watchdog: counts while enabled, flags when TIMEOUT_CYCLES-1 is reached.
module frame_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 2604
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Saturates at LAST so a stuck enable can never wrap into a false restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && (cnt != LAST))
            cnt <= cnt + CW'(1);
    end

    assign expired = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/sha_frame_rx.sv
// Length-prefixed frame parser feeding the SHA-256 processor (SOF, LEN_HI, LEN_LO, payload).
// Optional inter-byte timeout enabled by defining SHA_FRAME_TIMEOUT_EN.
module sha_frame_rx
    import sha_frame_pkg::*;
#(
    parameter logic [7:0] SOF            = SOF_DEFAULT,
    parameter int         MAX_LEN        = 1024,
    parameter int         TIMEOUT_CYCLES = 2604
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    input  logic           busy,
    sha_frame_rx_if.master sha,
    output logic           frame_err,
    output logic [1:0]     err_code,
    output state_t         state_dbg
);

    generate
        if (MAX_LEN < 1 || MAX_LEN > 65535 || TIMEOUT_CYCLES < 2) begin : g_bad_param
            $error("sha_frame_rx: MAX_LEN must be 1..65535 and TIMEOUT_CYCLES >= 2");
        end
    endgenerate

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    state_t      state, state_nx;
    logic [7:0]  len_hi;
    logic [15:0] remaining;
    logic [15:0] len;
    logic        len_bad;
    logic        expired;

    logic        start_q, dv_q, last_q;
    logic [7:0]  data_q;
    logic        start_d, dv_d, last_d, err_d;
    logic [1:0]  err_code_d;

    assign len     = {len_hi, rx_data};
    assign len_bad = (len == 16'd0) || (len > MAX_LEN_W);

`ifdef SHA_FRAME_TIMEOUT_EN
    // Clearing throughout IDLE means each active state is entered with a fresh count.
    frame_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_valid || (state == IDLE)),
        .enable  (state != IDLE),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rx_valid && (rx_data == SOF) && !busy) state_nx = LEN_HI;
            LEN_HI:  if (rx_valid) state_nx = LEN_LO;
                     else if (expired) state_nx = IDLE;
            LEN_LO:  if (rx_valid) state_nx = len_bad ? IDLE : PAYLOAD;
                     else if (expired) state_nx = IDLE;
            PAYLOAD: if (rx_valid) begin
                         if (remaining == 16'd1) state_nx = IDLE;
                     end else if (expired) begin
                         state_nx = IDLE;
                     end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        start_d    = 1'b0;
        dv_d       = 1'b0;
        last_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code;
        case (state)
            IDLE: begin
                if (rx_valid && (rx_data == SOF) && busy) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_BUSY;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    start_d    = !len_bad;
                    err_d      = len_bad;
                    err_code_d = len_bad ? ERR_LEN : err_code;
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    dv_d   = 1'b1;
                    last_d = (remaining == 16'd1);
                end
            end
            default: ;
        endcase
        if (expired && !rx_valid && (state != IDLE)) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q   <= 1'b0;
            dv_q      <= 1'b0;
            last_q    <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            data_q    <= 8'h00;
            len_hi    <= 8'h00;
            remaining <= 16'd0;
        end else begin
            start_q   <= start_d;
            dv_q      <= dv_d;
            last_q    <= last_d;
            frame_err <= err_d;
            err_code  <= err_code_d;
            if (dv_d)
                data_q <= rx_data;
            if ((state == LEN_HI) && rx_valid)
                len_hi <= rx_data;
            if (start_d)
                remaining <= len;
            else if (dv_d)
                remaining <= remaining - 16'd1;
        end
    end

    assign sha.start      = start_q;
    assign sha.data_valid = dv_q;
    assign sha.data_last  = last_q;
    assign sha.data_in    = data_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_sha_frame_rx.sv
// Directed bench for sha_frame_rx: framing, length errors, busy refusal, timeout, reset abort.
module tb_sha_frame_rx;
  import sha_frame_pkg::*;

  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       busy = 1'b0;
  logic       frame_err;
  logic [1:0] err_code;
  state_t     state_dbg;

  sha_frame_rx_if sha_bus();

  sha_frame_rx #(
    .SOF(8'hA5),
    .MAX_LEN(1024),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .busy(busy),
    .sha(sha_bus.master),
    .frame_err(frame_err),
    .err_code(err_code),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  int start_cnt = 0;
  int dv_cnt = 0;
  int last_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (sha_bus.start) start_cnt++;
    if (sha_bus.data_valid) dv_cnt++;
    if (sha_bus.data_last) last_cnt++;
    if (frame_err) err_cnt++;
  end

  logic       obs_start, obs_dv, obs_last, obs_err;
  logic [7:0] obs_data;
  logic [1:0] obs_code;
  logic [7:0] exp_q[$];

  // driver: one-cycle strobe, sample the registered response one cycle later, then a gap
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    obs_start = sha_bus.start;
    obs_dv = sha_bus.data_valid;
    obs_last = sha_bus.data_last;
    obs_err = frame_err;
    obs_data = sha_bus.data_in;
    obs_code = err_code;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (sha_bus.start !== 1'b0) $display("FAIL rst_start got=%b exp=0", sha_bus.start); else passed++;
    checks++; if (sha_bus.data_valid !== 1'b0) $display("FAIL rst_dv got=%b exp=0", sha_bus.data_valid); else passed++;
    checks++; if (sha_bus.data_last !== 1'b0) $display("FAIL rst_last got=%b exp=0", sha_bus.data_last); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", frame_err); else passed++;
    checks++; if (sha_bus.data_in !== 8'h00) $display("FAIL rst_data got=%h exp=00", sha_bus.data_in); else passed++;
    checks++; if (err_code !== 2'd0) $display("FAIL rst_code got=%0d exp=0", err_code); else passed++;
    checks++; if (state_dbg !== IDLE) $display("FAIL rst_state got=%0d exp=0", state_dbg); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int s0 = start_cnt;
    int e0 = err_cnt;
    int l0 = last_cnt;
    int d0 = dv_cnt;
    logic [7:0] pl [3] = '{8'h61, 8'h62, 8'h63};
    logic [7:0] e;
    send_byte(8'hA5);
    send_byte(8'h00);
    checks++; if (obs_start !== 1'b0) $display("FAIL basic_early_start got=%b exp=0", obs_start); else passed++;
    send_byte(8'h03);
    checks++; if (obs_start !== 1'b1) $display("FAIL basic_start got=%b exp=1", obs_start); else passed++;
    checks++; if (obs_dv !== 1'b0) $display("FAIL basic_dv_on_len got=%b exp=0", obs_dv); else passed++;
    for (int i = 0; i < 3; i++) exp_q.push_back(pl[i]);
    for (int i = 0; i < 3; i++) begin
      send_byte(pl[i]);
      e = exp_q.pop_front();
      checks++; if (obs_dv !== 1'b1) $display("FAIL basic_dv[%0d] got=%b exp=1", i, obs_dv); else passed++;
      checks++; if (obs_data !== e) $display("FAIL basic_data[%0d] got=%h exp=%h", i, obs_data, e); else passed++;
      checks++; if (obs_last !== (i == 2)) $display("FAIL basic_last[%0d] got=%b exp=%b", i, obs_last, (i == 2)); else passed++;
    end
    checks++; if (start_cnt - s0 !== 1) $display("FAIL basic_start_count got=%0d exp=1", start_cnt - s0); else passed++;
    checks++; if (dv_cnt - d0 !== 3) $display("FAIL basic_dv_count got=%0d exp=3", dv_cnt - d0); else passed++;
    checks++; if (last_cnt - l0 !== 1) $display("FAIL basic_last_count got=%0d exp=1", last_cnt - l0); else passed++;
    checks++; if (err_cnt - e0 !== 0) $display("FAIL basic_err_count got=%0d exp=0", err_cnt - e0); else passed++;
    checks++; if (sha_bus.data_in !== 8'h63) $display("FAIL basic_data_hold got=%h exp=63", sha_bus.data_in); else passed++;
    checks++; if (state_dbg !== IDLE) $display("FAIL basic_state got=%0d exp=0", state_dbg); else passed++;
  endtask

  task automatic test_ff_a5();
    logic [7:0] pl [2] = '{8'hFF, 8'hA5};
    logic [7:0] e;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    for (int i = 0; i < 2; i++) exp_q.push_back(pl[i]);
    for (int i = 0; i < 2; i++) begin
      send_byte(pl[i]);
      e = exp_q.pop_front();
      checks++; if (obs_data !== e) $display("FAIL ffa5_data[%0d] got=%h exp=%h", i, obs_data, e); else passed++;
      checks++; if (obs_last !== (i == 1)) $display("FAIL ffa5_last[%0d] got=%b exp=%b", i, obs_last, (i == 1)); else passed++;
    end
    checks++; if (state_dbg !== IDLE) $display("FAIL ffa5_idle got=%0d exp=0", state_dbg); else passed++;
    send_byte(8'hA5);
    checks++; if (state_dbg !== LEN_HI) $display("FAIL ffa5_resync got=%0d exp=1", state_dbg); else passed++;
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h77);
    checks++; if (obs_data !== 8'h77) $display("FAIL ffa5_next_data got=%h exp=77", obs_data); else passed++;
    checks++; if (obs_last !== 1'b1) $display("FAIL ffa5_next_last got=%b exp=1", obs_last); else passed++;
  endtask

  task automatic test_bad_len();
    int s0 = start_cnt;
    int e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    checks++; if (obs_err !== 1'b1) $display("FAIL len0_err got=%b exp=1", obs_err); else passed++;
    checks++; if (obs_code !== ERR_LEN) $display("FAIL len0_code got=%0d exp=1", obs_code); else passed++;
    checks++; if (obs_start !== 1'b0) $display("FAIL len0_start got=%b exp=0", obs_start); else passed++;
    checks++; if (state_dbg !== IDLE) $display("FAIL len0_state got=%0d exp=0", state_dbg); else passed++;
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
    checks++; if (obs_err !== 1'b1) $display("FAIL len1025_err got=%b exp=1", obs_err); else passed++;
    checks++; if (obs_code !== ERR_LEN) $display("FAIL len1025_code got=%0d exp=1", obs_code); else passed++;
    checks++; if (state_dbg !== IDLE) $display("FAIL len1025_state got=%0d exp=0", state_dbg); else passed++;
    checks++; if (start_cnt - s0 !== 0) $display("FAIL badlen_start_count got=%0d exp=0", start_cnt - s0); else passed++;
    checks++; if (err_cnt - e0 !== 2) $display("FAIL badlen_err_count got=%0d exp=2", err_cnt - e0); else passed++;
    // LEN == MAX_LEN is the largest legal frame
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h00);
    checks++; if (obs_start !== 1'b1) $display("FAIL len1024_start got=%b exp=1", obs_start); else passed++;
    checks++; if (obs_err !== 1'b0) $display("FAIL len1024_err got=%b exp=0", obs_err); else passed++;
    checks++; if (state_dbg !== PAYLOAD) $display("FAIL len1024_state got=%0d exp=3", state_dbg); else passed++;
    do_reset();
  endtask

  task automatic test_busy();
    busy = 1'b1;
    send_byte(8'hA5);
    checks++; if (obs_err !== 1'b1) $display("FAIL busy_err got=%b exp=1", obs_err); else passed++;
    checks++; if (obs_code !== ERR_BUSY) $display("FAIL busy_code got=%0d exp=3", obs_code); else passed++;
    checks++; if (state_dbg !== IDLE) $display("FAIL busy_state got=%0d exp=0", state_dbg); else passed++;
    busy = 1'b0;
    send_byte(8'hA5);
    busy = 1'b1;
    send_byte(8'h00);
    send_byte(8'h01);
    checks++; if (obs_start !== 1'b1) $display("FAIL busy_frame_start got=%b exp=1", obs_start); else passed++;
    send_byte(8'h42);
    checks++; if (obs_data !== 8'h42) $display("FAIL busy_frame_data got=%h exp=42", obs_data); else passed++;
    checks++; if (obs_last !== 1'b1) $display("FAIL busy_frame_last got=%b exp=1", obs_last); else passed++;
    checks++; if (err_code !== ERR_BUSY) $display("FAIL busy_code_hold got=%0d exp=3", err_code); else passed++;
    busy = 1'b0;
  endtask

  task automatic test_timeout();
    int e0 = err_cnt;
    int l0 = last_cnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h11);
    checks++; if (obs_data !== 8'h11) $display("FAIL to_data got=%h exp=11", obs_data); else passed++;
`ifdef SHA_FRAME_TIMEOUT_EN
    begin
      int n = 0;
      while (!frame_err && n < TO + 10) begin
        @(negedge clk);
        n++;
      end
      checks++; if (frame_err !== 1'b1) $display("FAIL to_err got=%b exp=1", frame_err); else passed++;
      checks++; if (n !== TO - 3) $display("FAIL to_delay got=%0d exp=%0d", n, TO - 3); else passed++;
      checks++; if (err_code !== ERR_TIMEOUT) $display("FAIL to_code got=%0d exp=2", err_code); else passed++;
      checks++; if (state_dbg !== IDLE) $display("FAIL to_state got=%0d exp=0", state_dbg); else passed++;
      repeat (2) @(negedge clk);
      checks++; if (last_cnt - l0 !== 0) $display("FAIL to_no_last got=%0d exp=0", last_cnt - l0); else passed++;
    end
`else
    repeat (TO + 10) @(negedge clk);
    checks++; if (state_dbg !== PAYLOAD) $display("FAIL nto_state got=%0d exp=3", state_dbg); else passed++;
    checks++; if (err_cnt - e0 !== 0) $display("FAIL nto_err got=%0d exp=0", err_cnt - e0); else passed++;
    checks++; if (last_cnt - l0 !== 0) $display("FAIL nto_no_last got=%0d exp=0", last_cnt - l0); else passed++;
`endif
    do_reset();
  endtask

  task automatic test_reset_midframe();
    int l0;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    l0 = last_cnt;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (sha_bus.data_in !== 8'h00) $display("FAIL mid_rst_data got=%h exp=00", sha_bus.data_in); else passed++;
    checks++; if (err_code !== 2'd0) $display("FAIL mid_rst_code got=%0d exp=0", err_code); else passed++;
    checks++; if (state_dbg !== IDLE) $display("FAIL mid_rst_state got=%0d exp=0", state_dbg); else passed++;
    checks++; if ({sha_bus.start, sha_bus.data_valid, sha_bus.data_last, frame_err} !== 4'b0)
      $display("FAIL mid_rst_strobes got=%b exp=0000", {sha_bus.start, sha_bus.data_valid, sha_bus.data_last, frame_err});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    checks++; if (obs_start !== 1'b1) $display("FAIL mid_next_start got=%b exp=1", obs_start); else passed++;
    send_byte(8'h33);
    checks++; if (obs_data !== 8'h33) $display("FAIL mid_next_data got=%h exp=33", obs_data); else passed++;
    checks++; if (obs_last !== 1'b1) $display("FAIL mid_next_last got=%b exp=1", obs_last); else passed++;
    checks++; if (last_cnt - l0 !== 1) $display("FAIL mid_last_count got=%0d exp=1", last_cnt - l0); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ff_a5();
    test_bad_len();
    test_busy();
    test_timeout();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
